// File: rtl/serdes_piso_tx.sv
// serdes_piso_tx: parallel-in/serial-out transmitter, LSB first, with a frame-sync strobe after each word.
// Optional feature macro SERDES_TX_IDLE_FILL_EN: send IDLE_WORD fill frames whenever no word is waiting.
module serdes_piso_tx #(
    parameter int               WIDTH     = 10,
    parameter logic [WIDTH-1:0] IDLE_WORD = 10'b0011111010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             ser_out,
    output logic             frame_sync,
    output logic             tx_busy,
    output logic             fill_active
);
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_SYNC
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] hold_data;
    logic [WIDTH-1:0] load_data;
    logic             hold_valid;
    logic             accept;
    logic             load;
    logic             take_hold;
    logic [CNT_W-1:0] bit_cnt;

    // Ready depends only on the holding register, never on tx_valid.
    assign tx_ready = !hold_valid;
    assign accept   = tx_valid && tx_ready;
    assign tx_busy  = (state != S_IDLE);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt  = state;
        load       = 1'b0;
        take_hold  = 1'b0;
        load_data  = hold_data;
        ser_out    = 1'b0;
        frame_sync = 1'b0;
        case (state)
            S_SHIFT: begin
                ser_out = sreg[0];
                if (bit_cnt == LAST_BIT) state_nxt = S_SYNC;
            end
            S_IDLE, S_SYNC: begin
                frame_sync = (state == S_SYNC);
                if (hold_valid) begin
                    load      = 1'b1;
                    take_hold = 1'b1;
                    state_nxt = S_SHIFT;
                end
`ifdef SERDES_TX_IDLE_FILL_EN
                else begin
                    load      = 1'b1;
                    load_data = IDLE_WORD;
                    state_nxt = S_SHIFT;
                end
`else
                else begin
                    state_nxt = S_IDLE;
                end
`endif
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments, so every register samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            sreg       <= '0;
            hold_data  <= '0;
            hold_valid <= 1'b0;
            bit_cnt    <= '0;
        end else begin
            state <= state_nxt;
            // A new word can only land when the hold is empty, so it never collides with a move.
            if (accept) begin
                hold_data  <= tx_data;
                hold_valid <= 1'b1;
            end else if (take_hold) begin
                hold_valid <= 1'b0;
            end
            if (load) begin
                sreg    <= load_data;
                bit_cnt <= '0;
            end else if (state == S_SHIFT) begin
                sreg    <= sreg >> 1;
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

`ifdef SERDES_TX_IDLE_FILL_EN
    logic fill_q;

    // The flag follows the frame on the line until the next load replaces it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fill_q <= 1'b0;
        end else if (load) begin
            fill_q <= !take_hold;
        end
    end

    assign fill_active = fill_q;
`else
    assign fill_active = 1'b0;
`endif

endmodule

// File: tb/tb_serdes_piso_tx.sv
// tb_serdes_piso_tx: directed bench for serdes_piso_tx with a line-timeline model and a loopback scoreboard.
// Covers the default build and, when SERDES_TX_IDLE_FILL_EN is defined, the fill-frame behaviour.
module tb_serdes_piso_tx;
    localparam int         WIDTH     = 10;
    localparam logic [9:0] IDLE_WORD = 10'b0011111010;
`ifdef SERDES_TX_IDLE_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic [9:0] tx_data  = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ser_out, frame_sync, tx_busy, fill_active;

    always #5 clk = ~clk;

    serdes_piso_tx #(.WIDTH(WIDTH), .IDLE_WORD(IDLE_WORD)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ser_out    (ser_out),
        .frame_sync (frame_sync),
        .tx_busy    (tx_busy),
        .fill_active(fill_active)
    );

    // One entry per future cycle of line activity: bit, sync strobe and fill flag.
    typedef struct packed {
        logic ser;
        logic sync;
        logic fill;
    } slot_t;

    slot_t      exp_q[$];
    logic [9:0] sb[$];
    int         m_drop  = 0;
    bit         m_hold  = 1'b0;
    logic [9:0] m_word  = '0;
    bit         started = 1'b0;
    int         cyc     = 0;

    int         n_vec = 0;
    int         n_err = 0;
    int         fs_log[$];
    logic [9:0] rx      = '0;
    logic [9:0] last_rx = '0;
    int         rd_idx  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_frame(input logic [9:0] w, input logic f);
        for (int k = 0; k < WIDTH; k++) exp_q.push_back('{ser: w[k], sync: 1'b0, fill: f});
        exp_q.push_back('{ser: 1'b0, sync: 1'b1, fill: f});
    endtask

    // Model: a frame takes the line for WIDTH bit cycles plus one sync cycle; a held word
    // goes onto the line at the first edge where the line has nothing left scheduled.
    always @(posedge clk) begin
        logic acc_m;
        acc_m = rst && tx_valid && !m_hold;
        if (!rst) begin
            exp_q.delete();
            m_hold  = 1'b0;
            m_drop  = sb.size();
            started = 1'b1;
        end else begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (exp_q.size() == 0) begin
                if (m_hold) begin
                    push_frame(m_word, 1'b0);
                    m_hold = 1'b0;
                end else if (FILL_EN) begin
                    push_frame(IDLE_WORD, 1'b1);
                end
            end
            if (acc_m) begin
                m_hold = 1'b1;
                m_word = tx_data;
                sb.push_back(tx_data);
            end
        end
        cyc++;
    end

    // Compare process: outputs against the model every cycle, plus a receiver-style reassembly.
    always @(negedge clk) begin
        slot_t e;
        if (started) begin
            e = (exp_q.size() != 0) ? exp_q[0] : slot_t'(0);
            check("ser_out", ser_out, e.ser);
            check("frame_sync", frame_sync, e.sync);
            check("fill_active", fill_active, e.fill);
            check("tx_busy", tx_busy, exp_q.size() != 0);
            check("tx_ready", tx_ready, !m_hold);
            if (rd_idx < m_drop) rd_idx = m_drop;
            if (tx_busy && !frame_sync) rx = {ser_out, rx[9:1]};
            if (frame_sync) begin
                last_rx = rx;
                fs_log.push_back(cyc);
                if (!fill_active) begin
                    if (rd_idx < sb.size()) begin
                        check("loopback", rx, sb[rd_idx]);
                    end else begin
                        n_vec++;
                        n_err++;
                        $display("FAIL loopback: got frame %0h, expected no frame (none outstanding)", rx);
                    end
                    rd_idx++;
                end
            end
        end
    end

    task automatic send(input logic [9:0] w, output int acc_cyc);
        int guard = 0;
        tx_data  = w;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: tx_ready got %b, expected 1 within 40 cycles", tx_ready);
        end
        @(negedge clk);
        acc_cyc = cyc;
    endtask

    task automatic wait_idle(input string name);
        int guard = 0;
        while (tx_busy !== 1'b0 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        check(name, tx_busy, 1'b0);
    endtask

    initial begin
        int         acc, l0, n0, r0, guard;
        logic [9:0] got;
        logic [9:0] w;
        got = '0;

        repeat (3) @(negedge clk);
        check("rst_ready", tx_ready, 1'b1);
        check("rst_ser", ser_out, 1'b0);
        check("rst_sync", frame_sync, 1'b0);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_fill", fill_active, 1'b0);
        rst = 1'b1;
        r0  = cyc;

`ifndef SERDES_TX_IDLE_FILL_EN
        // Single word: 10'h2A5 leaves as 1,0,1,0,0,1,0,1,0,1 then one sync cycle.
        send(10'h2A5, acc);
        tx_valid = 1'b0;
        check("t1_hold_full", tx_ready, 1'b0);
        @(negedge clk);
        for (int k = 0; k < WIDTH; k++) begin
            got[k] = ser_out;
            @(negedge clk);
        end
        check("t1_bits", got, 10'h2A5);
        check("t1_sync", frame_sync, 1'b1);
        @(negedge clk);
        check("t1_idle_ser", ser_out, 1'b0);
        check("t1_idle_sync", frame_sync, 1'b0);
        check("t1_idle_busy", tx_busy, 1'b0);

        // Back-to-back: syncs land 10, 21 and 32 cycles after the first load.
        send(10'h3FF, acc);
        l0 = acc + 1;
        n0 = fs_log.size();
        send(10'h001, acc);
        check("t2_ready_low", tx_ready, 1'b0);
        send(10'h155, acc);
        tx_valid = 1'b0;
        wait_idle("t2_drain");
        check("t2_frames", fs_log.size() - n0, 3);
        if (fs_log.size() >= n0 + 3)
            for (int i = 0; i < 3; i++) check("t2_sync_cycle", fs_log[n0+i] - l0, 10 + 11 * i);
`endif

        // Loopback stream of random words.
        for (int i = 0; i < 100; i++) begin
            w = 10'($urandom);
            send(w, acc);
        end
        tx_valid = 1'b0;

`ifndef SERDES_TX_IDLE_FILL_EN
        wait_idle("t3_drain");
        check("t3_all_delivered", rd_idx, sb.size());

        // Reset at bit 5 of 10'h0F0 with 10'h3C3 held: frame aborted, held word dropped.
        send(10'h0F0, acc);
        l0 = acc + 1;
        send(10'h3C3, acc);
        tx_valid = 1'b0;
        n0 = fs_log.size();
        while (cyc < l0 + 5) @(negedge clk);
        check("t4_bit5", ser_out, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check("t4_rst_ser", ser_out, 1'b0);
        check("t4_rst_sync", frame_sync, 1'b0);
        check("t4_rst_ready", tx_ready, 1'b1);
        check("t4_rst_busy", tx_busy, 1'b0);
        check("t4_rst_fill", fill_active, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (25) @(negedge clk);
        check("t4_no_frames", fs_log.size() - n0, 0);

        // tx_valid asserted only while tx_ready is low: nothing extra is accepted.
        send(10'h111, acc);
        send(10'h222, acc);
        tx_valid = 1'b0;
        n0 = fs_log.size();
        for (int i = 0; i < 8; i++) begin
            tx_data  = 10'h3AA;
            tx_valid = !tx_ready;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        wait_idle("t5_drain");
        check("t5_frames", fs_log.size() - n0, 2);
        check("t5_all_delivered", rd_idx, sb.size());
`else
        // Fill mode: after a fresh reset the line carries fill frames every 11 cycles.
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        r0  = cyc;
        n0  = fs_log.size();
        guard = 0;
        while (fs_log.size() < n0 + 3 && guard < 60) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("fill_count", fs_log.size() - n0, 3);
        if (fs_log.size() >= n0 + 3) begin
            check("fill_first_sync", fs_log[n0] - r0, 11);
            check("fill_period", fs_log[n0+2] - fs_log[n0+1], 11);
        end
        check("fill_word", last_rx, IDLE_WORD);
        check("fill_flag", fill_active, 1'b1);

        send(10'h2A5, acc);
        tx_valid = 1'b0;
        guard = 0;
        while (!(frame_sync === 1'b1 && fill_active === 1'b0) && guard < 30) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("inject_word", last_rx, 10'h2A5);
        check("inject_fill", fill_active, 1'b0);
        check("inject_period", fs_log[fs_log.size()-1] - fs_log[fs_log.size()-2], 11);
        @(negedge clk);
        #1;
        check("refill_flag", fill_active, 1'b1);
        repeat (10) @(negedge clk);
        #1;
        check("refill_word", last_rx, IDLE_WORD);
        check("all_delivered", rd_idx, sb.size());
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog");
    end

endmodule
